// File: rtl/rv_mem_bridge.sv
// rv_mem_bridge: single-outstanding bridge from the multicycle core to a
// req/ack memory with variable wait states, misalignment and timeout errors.
// Optional single-entry read buffer enabled by defining RV_MEMBRIDGE_RDBUF_EN.
module rv_mem_bridge #(
    parameter int unsigned     AW       = 32,
    parameter int unsigned     DW       = 32,
    parameter int unsigned     TIMEOUT  = 16,
    parameter logic [DW-1:0]   ERR_DATA = DW'(32'hDEAD_BEEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_done,
    output logic          core_err,
    output logic          core_busy,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          err_nx;
    logic [DW-1:0] rdata_nx;
    logic          accept;

`ifdef RV_MEMBRIDGE_RDBUF_EN
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;
    logic          buf_hit;

    assign buf_hit = buf_valid && !core_we && (buf_addr == core_addr);
`endif

    // State and timeout counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state, counter and completion values
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        rdata_nx = core_rdata;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (core_req) begin
                    accept = 1'b1;
                    if (core_addr[1:0] != 2'b00) begin
                        state_nx = DONE;
                        err_nx   = 1'b1;
                        if (!core_we) rdata_nx = ERR_DATA;
                    end
`ifdef RV_MEMBRIDGE_RDBUF_EN
                    else if (buf_hit) begin
                        state_nx = DONE;
                        rdata_nx = buf_data;
                    end
`endif
                    else begin
                        state_nx = REQ;
                        cnt_nx   = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nx = DONE;
                    if (!mem_we) rdata_nx = mem_rdata;
                end else begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == CW'(TIMEOUT - 1)) begin
                        state_nx = DONE;
                        err_nx   = 1'b1;
                        if (!mem_we) rdata_nx = ERR_DATA;
                    end
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs; memory-side fields double as the access latch
    always_ff @(posedge clk) begin
        if (!rst) begin
            core_rdata <= '0;
            core_done  <= 1'b0;
            core_err   <= 1'b0;
            core_busy  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            core_rdata <= rdata_nx;
            core_done  <= (state_nx == DONE);
            core_err   <= err_nx;
            core_busy  <= (state_nx != IDLE);
            mem_req    <= (state_nx == REQ);
            if (accept) begin
                mem_we    <= core_we;
                mem_addr  <= {core_addr[AW-1:2], 2'b00};
                mem_wdata <= core_wdata;
            end
        end
    end

`ifdef RV_MEMBRIDGE_RDBUF_EN
    // Read buffer: filled by successful reads, dropped by any store
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (accept && core_we) begin
            buf_valid <= 1'b0;
        end else if (state == REQ && mem_ack && !mem_we) begin
            buf_valid <= 1'b1;
            buf_addr  <= mem_addr;
            buf_data  <= mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Self-checking bench for rv_mem_bridge with a completion scoreboard.
module tb_rv_mem_bridge;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;
`ifdef RV_MEMBRIDGE_RDBUF_EN
    localparam bit          RDBUF   = 1'b1;
`else
    localparam bit          RDBUF   = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_done, core_err, core_busy;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    exp_t        sb[$];
    logic [31:0] model_rdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    rv_mem_bridge #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_done(core_done),
        .core_err(core_err), .core_busy(core_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access; waits = wait cycles before ack (negative = never ack)
    task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mval, input int waits, input bit hit);
        exp_t e;
        exp_t o;
        int   rc;
        int   exp_rc;
        bit   got;
        bit   mis;
        bit   tmo;
        mis = (addr[1:0] != 2'b00);
        tmo = !mis && !hit && (waits < 0 || waits >= TIMEOUT);
        e.err = mis || tmo;
        if (we)         e.rdata = model_rdata;
        else if (e.err) e.rdata = ERR;
        else            e.rdata = mval;
        if (!we) model_rdata = e.rdata;
        sb.push_back(e);
        exp_rc = (mis || hit) ? 0 : (tmo ? TIMEOUT : waits + 1);

        @(negedge clk);
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wdata;
        mem_rdata  = we ? 32'hBAD0_0BAD : mval;
        rc  = 0;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                rc++;
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_we", 32'(mem_we), 32'(we));
                if (we) check("mem_wdata", mem_wdata, wdata);
                check("busy_req", 32'(core_busy), 32'd1);
                mem_ack = (waits >= 0) && (rc == waits + 1);
            end
            if (core_done) begin
                got      = 1'b1;
                core_req = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    o = sb.pop_front();
                    check("rdata", core_rdata, o.rdata);
                    check("err", 32'(core_err), 32'(o.err));
                end
                check("latency", 32'(k), 32'(exp_rc + 1));
                check("mem_req_cycles", 32'(rc), 32'(exp_rc));
                check("busy_done", 32'(core_busy), 32'd1);
            end
        end
        if (!got) begin
            check("done_wait", 32'd0, 32'd1);
            core_req = 1'b0;
            sb.delete();
        end
        @(negedge clk);
        mem_ack = 1'b0;
        check("done_pulse", 32'(core_done), 32'd0);
        check("busy_idle", 32'(core_busy), 32'd0);
        check("mem_req_idle", 32'(mem_req), 32'd0);
    endtask

    // Reset asserted during the second REQ cycle of a read
    task automatic reset_mid_req();
        int rc;
        bit hit2;
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h400;
        rc   = 0;
        hit2 = 1'b0;
        for (int k = 0; k < 10 && !hit2; k++) begin
            @(negedge clk);
            if (mem_req) rc++;
            if (rc == 2) hit2 = 1'b1;
        end
        check("mid_req_reached", 32'(hit2), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(core_busy), 32'd0);
        check("rst_done", 32'(core_done), 32'd0);
        check("rst_rdata", core_rdata, 32'd0);
        rst      = 1'b1;
        core_req = 1'b0;
        model_rdata = 32'd0;
        @(negedge clk);
        check("rst_no_late_done", 32'(core_done), 32'd0);
        check("rst_idle_busy", 32'(core_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; core_req = 1'b0; core_we = 1'b0;
        core_addr = '0; core_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        model_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_rdata", core_rdata, 32'd0);
        check("reset_done", 32'(core_done), 32'd0);
        check("reset_err", 32'(core_err), 32'd0);
        check("reset_busy", 32'(core_busy), 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run(1'b0, 32'h100, 32'h0, 32'h1234_5678, 0, 1'b0);
        run(1'b1, 32'h204, 32'hA5A5_A5A5, 32'h0, 3, 1'b0);
        run(1'b0, 32'h102, 32'h0, 32'h1111_1111, 0, 1'b0);
        run(1'b1, 32'h206, 32'h5A5A_5A5A, 32'h0, 0, 1'b0);
        run(1'b0, 32'h500, 32'h0, 32'h0000_0055, -1, 1'b0);
        run(1'b0, 32'h504, 32'h0, 32'h7777_7777, TIMEOUT - 1, 1'b0);

        reset_mid_req();
        run(1'b0, 32'h108, 32'h0, 32'hCAFE_F00D, 2, 1'b0);

        run(1'b0, 32'h300, 32'h0, 32'h0000_0001, 0, 1'b0);
        run(1'b0, 32'h300, 32'h0, 32'h0000_0001, 1, RDBUF);
        run(1'b1, 32'h300, 32'h0000_0099, 32'h0, 0, 1'b0);
        run(1'b0, 32'h300, 32'h0, 32'h0000_0002, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mem_bridge.md
Name: rv_mem_bridge

Overview:
- Sits between the multicycle core (control plane and datapath) and external instruction/data memory.
- Accepts one core memory access at a time: instruction fetch, load or store.
- Runs a req/ack handshake to a memory with variable wait states and returns read data plus a completion pulse.
- Also provides a busy/stall indication so the control FSM can hold its current state, and reports misaligned or timed-out accesses.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 16, maximum cycles in REQ without mem_ack before the access is aborted (1..255).
- ERR_DATA, 32'hDEAD_BEEF, value returned on core_rdata for an errored read.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- core_req  in  1  access request; level, held by core until core_done.
- core_we  in  1  1 = store, 0 = load/fetch.
- core_addr  in  AW  byte address.
- core_wdata  in  DW  store data.
- core_rdata  out  DW  read data; valid with core_done, held until the next read completes.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  qualifies core_done; 1 = misaligned or timeout.
- core_busy  out  1  access in flight (stall to control FSM).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address (word aligned).
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one or more cycles.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, except core_rdata, which goes to 0.
  - Timeout counter goes to 0.
  - Applies mid-access as well: mem_req drops the next cycle and no core_done is issued.
- States: IDLE, REQ, DONE.
- IDLE:
  - If core_req == 1, latch core_we, core_addr and core_wdata.
  - If core_addr[1:0] != 0, go to DONE with err=1. No memory access.
  - Otherwise go to REQ and clear the counter.
  - core_busy = 0.
- REQ:
  - mem_req = 1; mem_we, mem_addr and mem_wdata are driven from the latched values and stay stable.
  - core_busy = 1.
  - If mem_ack == 1, capture mem_rdata (reads only), set err=0 and go to DONE.
  - Otherwise increment the counter. When the counter == TIMEOUT-1 and mem_ack == 0, set err=1 and go to DONE.
  - mem_ack takes priority over timeout in the same cycle.
- DONE:
  - core_done = 1 and core_err = err for exactly one cycle; core_busy = 1.
  - Always return to IDLE.
- core_rdata update rules:
  - Updated on entering DONE for reads only.
  - Errored read: core_rdata = ERR_DATA.
  - Stores leave core_rdata unchanged.
- mem_ack is ignored outside REQ.
- Minimum latency is core_req at cycle N, mem_req at N+1, mem_ack at N+1, core_done at N+2.
- A core_req still high in the cycle after DONE starts a new access; the core must drop req on core_done.
- Input changes while busy are ignored, because values are latched.
- Exactly one outstanding access at any time.

Optional Feature:
- Macro: RV_MEMBRIDGE_RDBUF_EN.
- With the macro defined, a single-entry read buffer holds {valid, addr, data} of the last successful read.
  - An aligned read in IDLE whose address matches a valid entry goes IDLE to DONE directly: no mem_req, core_rdata = buffered data, core_done at N+1.
  - Any store invalidates the buffer. A store to the same address also invalidates it.
  - Errored reads do not fill the buffer.
  - Reset clears valid.
- Without the macro, every read goes through REQ and behaviour is exactly as above.

Test Plan:
- Read with zero wait: core_req=1, we=0, addr=0x100; mem_ack at the first REQ cycle with rdata=0x12345678. Required: mem_req high for 1 cycle, core_done at cycle 2, core_rdata=0x12345678, core_err=0.
- Store with 3 wait states: addr=0x204, wdata=0xA5A5A5A5, mem_ack after 3 cycles. Required: mem_we=1 and mem_addr/mem_wdata stable for all 4 REQ cycles, one core_done pulse, core_rdata unchanged.
- Misaligned: addr=0x102, read. Required: mem_req never asserted, core_done and core_err at cycle 1, core_rdata=0xDEADBEEF.
- Timeout: TIMEOUT=16, no mem_ack. Required: mem_req high for exactly 16 cycles, core_err=1, core_rdata=ERR_DATA. An ack arriving in the 16th cycle instead yields err=0.
- Reset mid-REQ: drive rst=0 during the 2nd REQ cycle. Required: mem_req=0 and core_busy=0 the next cycle, no core_done. After release, a new read completes normally.
- RDBUF_EN: read 0x300 (mem returns 0x1), read 0x300 again, which must give core_done at N+1 with no mem_req. Then store 0x300, then read 0x300, which must issue mem_req again.
